// File: rtl/controle_revelacao.sv
// Control FSM for the class-reveal game: seed selection, per-player hide/show cycle, end of game.
// Optional macro TIMEOUT_EN adds an auto-advance out of MOSTRA after TEMPO_EXIBE cycles.
module controle_revelacao #(
  parameter int TEMPO_EXIBE = 100,
  parameter int NT          = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       confirma,
  input  logic       CJ_fim,
  output logic       zera_CS,
  output logic       rst_global,
  output logic       e_seed_reg,
  output logic       zera_CJ,
  output logic       inc_jogador,
  output logic       mostra_classe,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    ESCOLHE_SEED = 4'd1,
    REGISTRA     = 4'd2,
    ESCONDE      = 4'd3,
    MOSTRA       = 4'd4,
    PROXIMO      = 4'd5,
    FIM          = 4'd6
  } estado_t;

  estado_t estado, proximo;
  logic    confirma_q;
  logic    pulso_conf;
  logic    timeout;

  if (TEMPO_EXIBE < 1 || TEMPO_EXIBE > (1 << NT) - 1) begin : g_cfg_invalid
    $error("controle_revelacao: TEMPO_EXIBE does not fit in NT bits");
  end

  // confirma_q resets to 1 so a button held through reset yields no pulse
  always_ff @(posedge clock) begin
    if (reset) confirma_q <= 1'b1;
    else       confirma_q <= confirma;
  end

  assign pulso_conf = confirma & ~confirma_q;

`ifdef TIMEOUT_EN
  logic [NT-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || estado != MOSTRA) cnt <= '0;
    else                           cnt <= cnt + NT'(1);
  end

  assign timeout = (estado == MOSTRA) && (cnt == NT'(TEMPO_EXIBE - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  always_comb begin
    proximo       = INICIAL;
    zera_CS       = 1'b0;
    rst_global    = 1'b0;
    e_seed_reg    = 1'b0;
    zera_CJ       = 1'b0;
    inc_jogador   = 1'b0;
    mostra_classe = 1'b0;
    pronto        = 1'b0;
    case (estado)
      INICIAL: begin
        rst_global = 1'b1;
        zera_CS    = 1'b1;
        zera_CJ    = 1'b1;
        proximo    = ESCOLHE_SEED;
      end
      ESCOLHE_SEED: proximo = pulso_conf ? REGISTRA : ESCOLHE_SEED;
      REGISTRA: begin
        e_seed_reg = ~reset;
        zera_CJ    = 1'b1;
        proximo    = ESCONDE;
      end
      ESCONDE: proximo = pulso_conf ? MOSTRA : ESCONDE;
      MOSTRA: begin
        mostra_classe = 1'b1;
        // press and timeout in the same cycle still give a single advance
        proximo = (pulso_conf || timeout) ? PROXIMO : MOSTRA;
      end
      PROXIMO: begin
        inc_jogador = ~CJ_fim & ~reset;
        proximo     = CJ_fim ? FIM : ESCONDE;
      end
      FIM: begin
        pronto  = 1'b1;
        proximo = pulso_conf ? INICIAL : FIM;
      end
      default: proximo = INICIAL;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_controle_revelacao.sv
// Scoreboard bench for controle_revelacao: driver queues expected state/outputs, monitor compares each cycle.
module tb_controle_revelacao;

  logic       clock = 1'b0;
  logic       reset, confirma, CJ_fim;
  logic       zera_CS, rst_global, e_seed_reg, zera_CJ, inc_jogador, mostra_classe, pronto;
  logic [3:0] db_estado;

  int tests = 0;
  int fails = 0;
  int inc_cnt = 0;
  int win_cnt = 0;
  logic mostra_prev = 1'b0;

  typedef struct {
    logic [3:0] st;
    logic [6:0] out;
  } exp_t;

  exp_t sb[$];

  controle_revelacao #(.TEMPO_EXIBE(8), .NT(4)) dut (
    .clock(clock), .reset(reset), .confirma(confirma), .CJ_fim(CJ_fim),
    .zera_CS(zera_CS), .rst_global(rst_global), .e_seed_reg(e_seed_reg),
    .zera_CJ(zera_CJ), .inc_jogador(inc_jogador), .mostra_classe(mostra_classe),
    .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // {zera_CS, rst_global, e_seed_reg, zera_CJ, inc_jogador, mostra_classe, pronto}
  function automatic logic [6:0] expect_out(input logic [3:0] st, input logic f, input logic r);
    case (st)
      4'd0:    return 7'b1101000;
      4'd2:    return {2'b00, ~r, 4'b1000};
      4'd4:    return 7'b0000010;
      4'd5:    return {4'b0000, ~f & ~r, 2'b00};
      4'd6:    return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  // drive one cycle's inputs and queue the state expected to be visible during it
  task automatic cyc(input logic c, input logic f, input logic r, input logic [3:0] st);
    exp_t e;
    @(posedge clock);
    #1;
    confirma = c;
    CJ_fim   = f;
    reset    = r;
    e.st  = st;
    e.out = expect_out(st, f, r);
    sb.push_back(e);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    logic [6:0] got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {zera_CS, rst_global, e_seed_reg, zera_CJ, inc_jogador, mostra_classe, pronto};
      tests++;
      if (db_estado !== e.st || got !== e.out) begin
        fails++;
        $display("FAIL cycle t=%0t: got st=%0d out=%b, want st=%0d out=%b",
                 $time, db_estado, got, e.st, e.out);
      end
      if (inc_jogador === 1'b1) inc_cnt++;
      if (mostra_classe === 1'b1 && !mostra_prev) win_cnt++;
      mostra_prev = mostra_classe;
    end
  end

  initial begin
    reset = 1'b1; confirma = 1'b0; CJ_fim = 1'b0;
    repeat (2) @(posedge clock);

    // reset and release
    cyc(0, 0, 1, 4'd0);
    cyc(0, 0, 0, 4'd0);
    cyc(0, 0, 0, 4'd1);

    // long press in ESCOLHE_SEED: one e_seed_reg pulse, then parked in ESCONDE
    cyc(1, 0, 0, 4'd1);
    cyc(1, 0, 0, 4'd2);
    repeat (8) cyc(1, 0, 0, 4'd3);
    repeat (2) cyc(0, 0, 0, 4'd3);

    // five players, CJ_fim only on the fifth
    @(negedge clock); #1;
    inc_cnt = 0; win_cnt = 0;
    for (int p = 1; p <= 5; p++) begin
      logic f;
      f = (p == 5);
      cyc(1, f, 0, 4'd3);
      cyc(0, f, 0, 4'd4);
      cyc(1, f, 0, 4'd4);
      cyc(0, f, 0, 4'd5);
    end
    cyc(0, 1, 0, 4'd6);
    cyc(0, 1, 0, 4'd6);
    @(negedge clock); #1;
    check_int("inc_pulses", inc_cnt, 4);
    check_int("mostra_windows", win_cnt, 5);

    // press in FIM starts a new game
    cyc(1, 1, 0, 4'd6);
    cyc(0, 0, 0, 4'd0);
    cyc(0, 0, 0, 4'd1);

    // reset while in MOSTRA
    cyc(1, 0, 0, 4'd1);
    cyc(0, 0, 0, 4'd2);
    cyc(1, 0, 0, 4'd3);
    cyc(0, 0, 0, 4'd4);
    @(negedge clock); #1;
    inc_cnt = 0;
    cyc(0, 0, 1, 4'd4);
    cyc(0, 0, 0, 4'd0);
    cyc(0, 0, 0, 4'd1);
    @(negedge clock); #1;
    check_int("inc_after_reset_mostra", inc_cnt, 0);

    // reset in PROXIMO with the button held through it: no inc, no pulse afterwards
    cyc(1, 0, 0, 4'd1);
    cyc(0, 0, 0, 4'd2);
    cyc(1, 0, 0, 4'd3);
    cyc(0, 0, 0, 4'd4);
    cyc(1, 0, 0, 4'd4);
    cyc(1, 0, 1, 4'd5);
    cyc(1, 0, 0, 4'd0);
    cyc(1, 0, 0, 4'd1);
    cyc(0, 0, 0, 4'd1);
    cyc(0, 0, 0, 4'd1);

`ifdef TIMEOUT_EN
    // no press in MOSTRA: shown exactly 8 cycles, then PROXIMO
    cyc(1, 0, 0, 4'd1);
    cyc(0, 0, 0, 4'd2);
    cyc(1, 0, 0, 4'd3);
    cyc(0, 0, 0, 4'd4);
    repeat (7) cyc(0, 0, 0, 4'd4);
    cyc(0, 0, 0, 4'd5);
    cyc(0, 0, 0, 4'd3);
`endif

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    #1;
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controle_revelacao.md
CONTROLE_REVELACAO -- requirements
Module: controle_revelacao

Interface
REQ-001 Parameter TEMPO_EXIBE, default 100, number of clock cycles a class stays shown before auto-advance (used only with TIMEOUT_EN).
REQ-002 Parameter NT, default 7, width of the timeout counter, with TEMPO_EXIBE <= 2^NT - 1.
REQ-003 clock  in  1  single system clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset; dominates every other input.
REQ-005 confirma  in  1  level from the confirm button; the block detects its edges internally.
REQ-006 CJ_fim  in  1  from the player counter; high when the current player is the last one.
REQ-007 zera_CS  out  1  clears the seed counter.
REQ-008 rst_global  out  1  clears the seed register and the datapath seed edge detector.
REQ-009 e_seed_reg  out  1  loads the selected seed into the seed register.
REQ-010 zera_CJ  out  1  clears the player counter.
REQ-011 inc_jogador  out  1  advances the player counter by one.
REQ-012 mostra_classe  out  1  enables the display of classe_atual.
REQ-013 pronto  out  1  all players have seen their class.
REQ-014 db_estado  out  4  current state code, for debug.

Function
REQ-015 The block SHALL register confirma once and form pulso_conf = confirma AND NOT confirma_q, giving one pulse per press regardless of hold length.
REQ-016 The FSM SHALL be Moore with these state codes: INICIAL=0, ESCOLHE_SEED=1, REGISTRA=2, ESCONDE=3, MOSTRA=4, PROXIMO=5, FIM=6; codes 7-15 are illegal and SHALL go to INICIAL on the next clock.
REQ-017 INICIAL: rst_global=1, zera_CS=1, zera_CJ=1; unconditional transition to ESCOLHE_SEED.
REQ-018 ESCOLHE_SEED: all outputs 0, so the seed counter runs from the datapath button; pulso_conf SHALL move to REGISTRA.
REQ-019 REGISTRA: e_seed_reg=1 and zera_CJ=1 for exactly one cycle; unconditional transition to ESCONDE.
REQ-020 ESCONDE: mostra_classe=0; pulso_conf SHALL move to MOSTRA.
REQ-021 MOSTRA: mostra_classe=1; pulso_conf SHALL move to PROXIMO.
REQ-022 PROXIMO: lasts one cycle; if CJ_fim=1, go to FIM with inc_jogador=0; otherwise set inc_jogador=1 and go to ESCONDE.
REQ-023 FIM: pronto=1; pulso_conf SHALL move to INICIAL to start a new game.
REQ-024 inc_jogador and e_seed_reg SHALL never be high for more than one consecutive cycle.
REQ-025 db_estado SHALL equal the state register in every cycle.
REQ-026 A confirm press held across a transition SHALL NOT produce a second advance; a new advance needs a fresh 0 to 1 edge.

Reset
REQ-027 While reset=1, on the next edge the state SHALL become INICIAL, confirma_q SHALL become 1, and the timeout counter SHALL become 0.
REQ-028 Setting confirma_q to 1 means a button held through reset produces no pulse.
REQ-029 Outputs after reset SHALL be: rst_global=1, zera_CS=1, zera_CJ=1, and all others 0 (db_estado=0).
REQ-030 Reset in any state, mid-game included, SHALL abort the game; no e_seed_reg or inc_jogador pulse is issued in the reset cycle.

Configuration
REQ-031 With macro TIMEOUT_EN defined, an NT-bit counter SHALL clear on entry to MOSTRA and increment each cycle in MOSTRA.
REQ-032 With TIMEOUT_EN, reaching TEMPO_EXIBE-1 SHALL force the transition to PROXIMO.
REQ-033 With TIMEOUT_EN, if pulso_conf and the timeout coincide, exactly one advance SHALL occur.
REQ-034 Without TIMEOUT_EN, the counter SHALL be absent and MOSTRA SHALL exit only on pulso_conf.

Verification
REQ-035 Reset, then release -> db_estado=0 with rst_global=zera_CS=zera_CJ=1 for one cycle, then db_estado=1 with all outputs 0.
REQ-036 In ESCOLHE_SEED, hold confirma high for 10 cycles -> exactly one e_seed_reg pulse, then db_estado=3 and it stays there.
REQ-037 Five players, CJ_fim high only on the fifth: press/release pairs -> 4 inc_jogador pulses, 5 mostra_classe windows, then pronto=1 and db_estado=6.
REQ-038 Assert reset while in MOSTRA -> next cycle db_estado=0 and mostra_classe=0, with no inc_jogador pulse.
REQ-039 With TIMEOUT_EN and TEMPO_EXIBE=8, no press in MOSTRA -> mostra_classe high exactly 8 cycles, then PROXIMO.
REQ-040 In FIM, one press -> db_estado=0, then db_estado=1, and a new game can start.
